// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg -- shared definitions for the instruction-decode stage.
//   * Opcode values of the 6-bit primary opcode field.
//   * alu_ctrl_e : ALU operation selector handed to EX.
//   * id_bundle_t: control part of the registered ID->EX bundle.
//   * out_state_e: occupancy state of the ID->EX output register.
// Optional build macro: ID_ILLEGAL_TRAP_EN adds the 'illegal' flag to the
// bundle so unknown opcodes can be reported downstream.
// ---------------------------------------------------------------------------
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000101;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ADD_R   = 4'd1,
    ADD_I   = 4'd2,
    SUB_CMP = 4'd3
  } alu_ctrl_e;

  typedef struct packed {
    alu_ctrl_e alu_ctrl;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
`ifdef ID_ILLEGAL_TRAP_EN
    logic      illegal;
`endif
  } id_bundle_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/id_regfile.sv
// ---------------------------------------------------------------------------
// id_regfile -- 2-read / 1-write architectural register file.
//   Reads are combinational; the write happens on the rising clock edge.
//   Register 0 always reads as zero and ignores writes. A write in the same
//   cycle as a read of the same (non-zero) register is bypassed to the read
//   port, so the decode stage sees the value being written back.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   we_i, waddr_i, wdata_i  write port
//   raddr1_i, raddr2_i      read addresses
//   rdata1_o, rdata2_o      read data (with write-back bypass)
// ---------------------------------------------------------------------------
module id_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int RADDR_W  = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]    wdata_i,
  input  logic [RADDR_W-1:0] raddr1_i,
  input  logic [RADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]    rdata1_o,
  output logic [XLEN-1:0]    rdata2_o
);

  // Register 0 has no storage; only 1..NUM_REGS-1 are real flops.
  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[g] <= '0;
      end else if (we_i && (waddr_i == RADDR_W'(g))) begin
        regs_q[g] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (raddr1_i == RADDR_W'(i)) rdata1_o = regs_q[i];
      if (raddr2_i == RADDR_W'(i)) rdata2_o = regs_q[i];
    end
    // Write-back bypass; never applies to register 0.
    if (we_i && (raddr1_i != '0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (raddr2_i != '0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe -- registered instruction-decode stage (IF/ID -> EX).
//   Decodes a 32-bit MIPS-style word, reads operands from id_regfile
//   (with write-back bypass), sign-extends imm16, stalls on load-use hazards
//   and hands a registered bundle to EX over valid/ready. flush squashes
//   both the held bundle and the incoming instruction.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr/in_pc  upstream handshake and instruction
//   flush                             squash request (highest priority)
//   wb_en/wb_addr/wb_data             register write-back
//   ex_is_load/ex_rd                  EX-stage info for load-use detection
//   out_valid/out_ready               downstream handshake
//   out_pc, out_rs1_data, out_rs2_data, out_rd, out_alu_ctrl, out_imm,
//   out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal
// Build macro: ID_ILLEGAL_TRAP_EN -- when defined, unknown opcodes raise
//   out_illegal; otherwise they decode as a NOP and out_illegal is 0.
// ---------------------------------------------------------------------------
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int RADDR_W  = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ex_is_load,
  input  logic [RADDR_W-1:0] ex_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_rs1_data,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic [3:0]         out_alu_ctrl,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               out_branch,
  output logic               out_illegal
);

  // Field extraction; index bits above RADDR_W are dropped.
  logic [5:0]         opcode;
  logic [RADDR_W-1:0] rs, rt, rd_field;
  logic signed [15:0] imm16;

  assign opcode   = in_instr[31:26];
  assign rs       = in_instr[21 +: RADDR_W];
  assign rt       = in_instr[16 +: RADDR_W];
  assign rd_field = in_instr[11 +: RADDR_W];
  assign imm16    = signed'(in_instr[15:0]);

  // Decode
  id_bundle_t                dec;
  logic [RADDR_W-1:0]        dec_rd;
  logic signed [XLEN-1:0]    dec_imm;
  logic                      uses_rt;

  always_comb begin
    dec           = '0;
    dec.alu_ctrl  = ALU_NOP;
    dec_rd        = '0;
    dec_imm       = XLEN'(imm16);  // signed cast sign-extends
    uses_rt       = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.alu_ctrl  = ADD_R;
        dec.reg_write = 1'b1;
        dec_rd        = rd_field;
        dec_imm       = '0;
        uses_rt       = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_ctrl  = ADD_I;
        dec.reg_write = 1'b1;
        dec_rd        = rt;
      end
      OP_J: begin
        dec.branch    = 1'b1;
        dec_imm       = '0;
      end
      OP_LW: begin
        dec.alu_ctrl  = ADD_I;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec_rd        = rt;
      end
      OP_SW: begin
        dec.alu_ctrl  = ADD_I;
        dec.mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_ctrl  = SUB_CMP;
        dec.branch    = 1'b1;
        uses_rt       = 1'b1;
      end
      default: begin
        // Unknown opcode: all control flags stay at their NOP defaults.
`ifdef ID_ILLEGAL_TRAP_EN
        dec.illegal   = 1'b1;
`endif
      end
    endcase
  end

  // Operand read
  logic [XLEN-1:0] rs1_val, rs2_val;

  id_regfile #(
    .XLEN    (XLEN),
    .NUM_REGS(NUM_REGS),
    .RADDR_W (RADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wb_en),
    .waddr_i (wb_addr),
    .wdata_i (wb_data),
    .raddr1_i(rs),
    .raddr2_i(rt),
    .rdata1_o(rs1_val),
    .rdata2_o(rs2_val)
  );

  // Hazard and handshake
  logic hazard, accept;

  assign hazard   = ex_is_load && (ex_rd != '0) &&
                    ((ex_rd == rs) || (uses_rt && (ex_rd == rt)));
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register FSM
  out_state_e         state_q, state_d;
  id_bundle_t         ctrl_q, ctrl_d;
  logic [XLEN-1:0]    pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [RADDR_W-1:0] rd_q, rd_d;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    // accept already excludes flush, so the load below never fires then.
    if (accept) begin
      ctrl_d = dec;
      pc_d   = in_pc;
      rs1_d  = rs1_val;
      rs2_d  = rs2_val;
      imm_d  = dec_imm;
      rd_d   = dec_rd;
    end
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FULL;
        ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ctrl_q  <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid     = (state_q == ST_FULL);
  assign out_pc        = pc_q;
  assign out_rs1_data  = rs1_q;
  assign out_rs2_data  = rs2_q;
  assign out_rd        = rd_q;
  assign out_alu_ctrl  = ctrl_q.alu_ctrl;
  assign out_imm       = imm_q;
  assign out_reg_write = ctrl_q.reg_write;
  assign out_mem_read  = ctrl_q.mem_read;
  assign out_mem_write = ctrl_q.mem_write;
  assign out_branch    = ctrl_q.branch;
`ifdef ID_ILLEGAL_TRAP_EN
  assign out_illegal   = ctrl_q.illegal;
`else
  assign out_illegal   = 1'b0;
`endif

endmodule
